// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter display path.
// Holds the converter FSM states and the decimal-range helper.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SEND    = 2'd2
    } fsm_state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned acc;
        acc = 1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift
// the BCD vector left by one with the binary MSB entering bit 0.
module bcd_dabble_step #(
    parameter int DIGITS = 6
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    input  logic                i_msb,
    output logic [4*DIGITS-1:0] o_bcd
);

    logic [4*DIGITS-1:0] w_adj;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[4*gi +: 4] = (i_bcd[4*gi +: 4] >= 4'd5) ?
                                      (i_bcd[4*gi +: 4] + 4'd3) :
                                      i_bcd[4*gi +: 4];
        end
    endgenerate

    // The top bit falls off here; it can only be set when the value overflowed.
    assign o_bcd = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, i_msb};

endmodule

// File: rtl/axis_bin_to_bcd.sv
// AXI-stream binary-to-BCD converter feeding the seven-segment controller.
// One count in, one saturating packed-BCD result out, BIN_WIDTH shift cycles each.
module axis_bin_to_bcd
    import freq_meter_pkg::*;
#(
    parameter int         BIN_WIDTH = 20,
    parameter int         DIGITS    = 6,
    parameter logic [7:0] DEST_ID   = 8'h7F
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [BIN_WIDTH-1:0]  s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [4*DIGITS-1:0]   m_tdata,
    output logic                  m_tuser,
    output logic [7:0]            m_tdest
);

    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int CMP_W = (BIN_WIDTH > 27) ? BIN_WIDTH : 27;
    localparam logic [CMP_W-1:0]    MAX_VAL   = CMP_W'(pow10(DIGITS) - 64'd1);
    localparam logic [CNT_W-1:0]    LAST_ITER = CNT_W'(BIN_WIDTH - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

    generate
        if (BIN_WIDTH < 1 || BIN_WIDTH > 32) begin : g_bad_bin_width
            $error("axis_bin_to_bcd: BIN_WIDTH must be in 1..32");
        end
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("axis_bin_to_bcd: DIGITS must be in 1..8");
        end
    endgenerate

    fsm_state_t             r_state;
    logic [BIN_WIDTH-1:0]   r_bin;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic                   r_s_tready;
    logic                   r_m_tvalid;
    logic [4*DIGITS-1:0]    r_m_tdata;
    logic                   r_m_tuser;

    logic [4*DIGITS-1:0]    w_bcd_next;
    logic                   w_ovf;

    // Widened compare so 10^DIGITS-1 is never truncated for narrow inputs.
    assign w_ovf = (CMP_W'(s_tdata) > MAX_VAL);

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .i_bcd  (r_bcd),
        .i_msb  (r_bin[BIN_WIDTH-1]),
        .o_bcd  (w_bcd_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tuser  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_s_tready <= 1'b1;
                    if (s_tvalid && r_s_tready) begin
                        r_bin      <= s_tdata;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf      <= w_ovf;
                        r_s_tready <= 1'b0;
                        r_state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_state    <= ST_SEND;
                        r_m_tvalid <= 1'b1;
                        r_m_tdata  <= r_ovf ? ALL_NINES : w_bcd_next;
                        r_m_tuser  <= r_ovf;
                    end
                end
                ST_SEND: begin
                    if (m_tready) begin
                        r_m_tvalid <= 1'b0;
                        r_s_tready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_tready = r_s_tready;
    assign m_tvalid = r_m_tvalid;
    assign m_tdata  = r_m_tdata;
    assign m_tuser  = r_m_tuser;
    assign m_tdest  = DEST_ID;

endmodule

// File: tb/tb_axis_bin_to_bcd.sv
// Randomized bench for axis_bin_to_bcd against a decimal-arithmetic reference.
// Covers reset, latency, overflow, backpressure, back-to-back and mid-flight reset.
module tb_axis_bin_to_bcd;

    localparam int BW  = 20;
    localparam int DG  = 6;
    localparam int LAT = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [BW-1:0] s_tdata = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [23:0]   m_tdata;
    logic          m_tuser;
    logic [7:0]    m_tdest;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    axis_bin_to_bcd #(
        .BIN_WIDTH (BW),
        .DIGITS    (DG),
        .DEST_ID   (8'h7F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tdest  (m_tdest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, saturating above 999999.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0]  r;
        int unsigned  x;
        r = '0;
        if (v > 999999) return 24'h999999;
        x = v;
        for (int d = 0; d < DG; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_tready && n < 60) begin
            tick();
            n++;
        end
        if (!s_tready) check_val("ready_timeout", 32'(s_tready), 32'd1);
    endtask

    task automatic wait_mvalid(output int lat);
        lat = 0;
        while (!m_tvalid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_xfer(input int unsigned value, input int stall);
        int          lat;
        logic [23:0] exp_d;
        logic        exp_u;
        logic [23:0] held;
        exp_d = ref_bcd(value);
        exp_u = (value > 999999);
        wait_ready();
        s_tvalid = 1'b1;
        s_tdata  = BW'(value);
        tick();
        s_tvalid = 1'b0;
        m_tready = (stall == 0);
        wait_mvalid(lat);
        check_val("latency", 32'(lat), 32'(LAT));
        check_val("tdata", 32'(m_tdata), 32'(exp_d));
        check_val("tuser", 32'(m_tuser), 32'(exp_u));
        check_val("tdest", 32'(m_tdest), 32'h7F);
        $display("xfer in=%0d out=%06h ovf=%0b lat=%0d stall=%0d", value, m_tdata, m_tuser, lat, stall);
        held = m_tdata;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_val("hold_valid", 32'(m_tvalid), 32'd1);
            check_val("hold_data", 32'(m_tdata), 32'(held));
            check_val("hold_sready", 32'(s_tready), 32'd0);
        end
        m_tready = 1'b1;
        tick();
        check_val("post_valid", 32'(m_tvalid), 32'd0);
        check_val("post_sready", 32'(s_tready), 32'd1);
    endtask

    initial begin
        int          lat;
        int          rise_prev;
        int unsigned v;

        // Reset held with s_tvalid asserted.
        s_tvalid = 1'b1;
        s_tdata  = BW'(5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("rst_sready", 32'(s_tready), 32'd0);
            check_val("rst_mvalid", 32'(m_tvalid), 32'd0);
            check_val("rst_mdata", 32'(m_tdata), 32'd0);
        end
        rst = 1'b1;
        #1;
        check_val("rel_sready", 32'(s_tready), 32'd0);
        tick();
        check_val("first_sready", 32'(s_tready), 32'd1);
        s_tvalid = 1'b0;
        $display("reset released, s_tready=%0b", s_tready);

        // Basic and overflow conversions.
        run_xfer(0, 0);
        run_xfer(123456, 0);
        run_xfer(999999, 0);
        run_xfer(1000000, 0);
        run_xfer(1048575, 0);

        // Backpressure.
        run_xfer(4321, 10);

        // Randomized traffic.
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 1048575);
                1:       v = $urandom_range(999990, 1000009);
                2:       v = $urandom_range(0, 99);
                default: v = $urandom_range(0, 999999);
            endcase
            run_xfer(v, int'($urandom_range(0, 3)));
        end

        // Back-to-back with s_tvalid held high.
        wait_ready();
        s_tvalid  = 1'b1;
        rise_prev = 0;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            s_tdata = BW'(7 + i);
            tick();
            wait_mvalid(lat);
            check_val("b2b_latency", 32'(lat), 32'(LAT));
            check_val("b2b_data", 32'(m_tdata), 32'(ref_bcd(7 + i)));
            if (i > 0) check_val("b2b_spacing", 32'(cyc - rise_prev), 32'd22);
            $display("b2b in=%0d out=%06h cycle=%0d", 7 + i, m_tdata, cyc);
            rise_prev = cyc;
            tick();
            check_val("b2b_sready", 32'(s_tready), 32'd1);
        end
        s_tvalid = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_tvalid) lat++;
        end
        check_val("b2b_no_dup", 32'(lat), 32'd0);

        // Reset in the middle of a conversion.
        wait_ready();
        s_tvalid = 1'b1;
        s_tdata  = BW'(555555);
        tick();
        s_tvalid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check_val("midconv_mvalid", 32'(m_tvalid), 32'd0);
        check_val("midconv_sready", 32'(s_tready), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (m_tvalid) lat++;
        end
        check_val("midconv_no_out", 32'(lat), 32'd0);
        $display("reset during convert of 555555 done");
        run_xfer(42, 0);

        // Reset while a result waits for the consumer.
        wait_ready();
        s_tvalid = 1'b1;
        s_tdata  = BW'(777777);
        tick();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        wait_mvalid(lat);
        check_val("midsend_valid", 32'(m_tvalid), 32'd1);
        rst = 1'b0;
        #1;
        check_val("midsend_mvalid", 32'(m_tvalid), 32'd0);
        check_val("midsend_mdata", 32'(m_tdata), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        m_tready = 1'b1;
        tick();
        check_val("midsend_sready", 32'(s_tready), 32'd1);
        $display("reset during send of 777777 done");
        run_xfer(42, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
